wb_slave_regfile: RTL and testbench



---
 rtl/wb_pkg.sv | 60 ++++++
 rtl/wb_slave_regfile_if.sv | 26 ++
 rtl/wb_req_fifo.sv | 53 +++++
 rtl/wb_slave_regfile.sv | 128 ++++++++++++
 tb/tb_wb_slave_regfile.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types, sizes and helpers for the Wishbone register-file slave.
package wb_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int GRANULE      = 8;
    localparam int SEL_WIDTH    = DATA_WIDTH / GRANULE;
    localparam int REGISTER_NUM = 16;
    localparam int REG_IDX_W    = $clog2(REGISTER_NUM);

    localparam logic [DATA_WIDTH-1:0] ID_VALUE = 32'hC0DE_0002;

    // Bit positions inside the error vector produced by classify_req.
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_READONLY = 2;
    localparam int ERR_NOSEL    = 3;
    localparam int ERR_CODES    = 4;

    typedef logic [ERR_CODES-1:0] err_vec_t;

    // One accepted bus request as it sits in the response queue.
    // idx only keeps the bits needed to address the bank; out-of-range
    // requests are already marked with err and never touch the bank.
    typedef struct packed {
        logic                  we;
        logic [REG_IDX_W-1:0]  idx;
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0]  sel;
        logic                  err;
    } wb_req_t;

    // Decide at accept time which error conditions a request hits.
    function automatic err_vec_t classify_req(input logic [ADDR_WIDTH-1:0] adr,
                                              input logic                  we,
                                              input logic [SEL_WIDTH-1:0]  sel);
        logic [ADDR_WIDTH-3:0] idx;
        err_vec_t              e;
        idx             = adr[ADDR_WIDTH-1:2];
        e               = '0;
        e[ERR_MISALIGN] = (adr[1:0] != 2'b00);
        e[ERR_RANGE]    = (idx >= (ADDR_WIDTH-2)'(REGISTER_NUM));
        e[ERR_READONLY] = we && (idx == '0);
        e[ERR_NOSEL]    = (sel == '0);
        return e;
    endfunction

    // Replace only the byte lanes selected by sel.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_val,
                                                          input logic [DATA_WIDTH-1:0] new_val,
                                                          input logic [SEL_WIDTH-1:0]  sel);
        logic [DATA_WIDTH-1:0] r;
        r = old_val;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (sel[i]) r[i*GRANULE +: GRANULE] = new_val[i*GRANULE +: GRANULE];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_slave_regfile_if.sv
// Pipelined Wishbone bus between one master and the register-file slave.
interface wb_slave_regfile_if;
    import wb_pkg::*;

    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  stall_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o, stall_o
    );

endinterface

// File: rtl/wb_req_fifo.sv
// In-order request queue with synchronous flush; push and pop may coincide
// even when full (the popped slot is the one being refilled).
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  wb_req_t                wr_data,
    output wb_req_t                rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers and occupancy; flush drops every queued entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 pipelined slave: a bank of 32-bit registers with byte-lane
// writes, an in-order request queue and a configurable response delay.
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_slave_regfile_if.slave  bus
);

    localparam int               CNT_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [3:0]       WS       = 4'(WAIT_STATES);

    wb_req_t               new_req;
    wb_req_t               head;
    err_vec_t              req_errs;
    logic                  abort;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      count_next;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_next;
    logic                  stall_next;
    logic                  stall_q;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] regs [REGISTER_NUM];

    // Dropping cyc_i abandons everything outstanding.
    assign abort = !bus.cyc_i;

    // The head responds once it has waited WAIT_STATES cycles in place.
    assign pop  = bus.cyc_i && !fifo_empty && (wait_cnt >= WS);
    assign push = bus.cyc_i && bus.stb_i && !stall_q && (!fifo_full || pop);

    assign req_errs    = classify_req(bus.adr_i, bus.we_i, bus.sel_i);
    assign new_req.we  = bus.we_i;
    assign new_req.idx = bus.adr_i[REG_IDX_W+1:2];
    assign new_req.dat = bus.dat_i;
    assign new_req.sel = bus.sel_i;
    assign new_req.err = |req_errs;

    wb_req_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (abort),
        .push    (push),
        .pop     (pop),
        .wr_data (new_req),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Occupancy and head age one edge ahead, so stall_o can be registered
    // yet still drop on the cycle where a pop will free the full queue.
    always_comb begin
        count_next = fifo_count;
        wait_next  = wait_cnt;
        if (abort) begin
            count_next = '0;
            wait_next  = '0;
        end else begin
            if (push) count_next = count_next + CNT_W'(1);
            if (pop)  count_next = count_next - CNT_W'(1);
            if (pop) begin
                wait_next = '0;
            end else if (!fifo_empty && (wait_cnt < WS)) begin
                wait_next = wait_cnt + 4'd1;
            end
        end
        stall_next = !abort && (count_next == FULL_CNT) && (wait_next < WS);
    end

    // Wait counter and registered stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            stall_q  <= stall_next;
        end
    end

    // Response issue and register bank; writes land on the acking edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            for (int i = 0; i < REGISTER_NUM; i++) regs[i] <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            if (pop) begin
                if (head.err) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    if (head.we) begin
                        regs[head.idx] <= merge_lanes(regs[head.idx], head.dat, head.sel);
                    end else begin
                        dat_q <= (head.idx == '0) ? ID_VALUE : regs[head.idx];
                    end
                end
            end
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.dat_o   = dat_q;
    assign bus.stall_o = stall_q;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Bench for wb_slave_regfile: three instances (WAIT_STATES 0, 3 and 5)
// against a transaction-level register model and an in-order scoreboard.
module tb_wb_slave_regfile;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cyc [3];
    logic        stb [3];
    logic        we  [3];
    logic [15:0] adr [3];
    logic [31:0] dat [3];
    logic [3:0]  sel [3];
    logic        ack_w   [3];
    logic        err_w   [3];
    logic        stall_w [3];
    logic [31:0] dat_w   [3];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    exp_t        expq  [3][$];
    int          ack_t [3][$];
    int          ack_cnt   [3];
    int          err_cnt   [3];
    int          stall_cnt [3];
    logic [31:0] last_rd   [3];
    logic [31:0] mreg [3][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_slave_regfile_if bus0 ();
    wb_slave_regfile_if bus1 ();
    wb_slave_regfile_if bus2 ();

    wb_slave_regfile #(.QUEUE_DEPTH(2), .WAIT_STATES(0)) u_ws0 (.clk_i(clk), .rst_i(rst_i), .bus(bus0));
    wb_slave_regfile #(.QUEUE_DEPTH(2), .WAIT_STATES(3)) u_ws3 (.clk_i(clk), .rst_i(rst_i), .bus(bus1));
    wb_slave_regfile #(.QUEUE_DEPTH(2), .WAIT_STATES(5)) u_ws5 (.clk_i(clk), .rst_i(rst_i), .bus(bus2));

    assign bus0.cyc_i = cyc[0]; assign bus0.stb_i = stb[0]; assign bus0.we_i = we[0];
    assign bus0.adr_i = adr[0]; assign bus0.dat_i = dat[0]; assign bus0.sel_i = sel[0];
    assign bus1.cyc_i = cyc[1]; assign bus1.stb_i = stb[1]; assign bus1.we_i = we[1];
    assign bus1.adr_i = adr[1]; assign bus1.dat_i = dat[1]; assign bus1.sel_i = sel[1];
    assign bus2.cyc_i = cyc[2]; assign bus2.stb_i = stb[2]; assign bus2.we_i = we[2];
    assign bus2.adr_i = adr[2]; assign bus2.dat_i = dat[2]; assign bus2.sel_i = sel[2];

    assign ack_w[0] = bus0.ack_o; assign err_w[0] = bus0.err_o; assign stall_w[0] = bus0.stall_o; assign dat_w[0] = bus0.dat_o;
    assign ack_w[1] = bus1.ack_o; assign err_w[1] = bus1.err_o; assign stall_w[1] = bus1.stall_o; assign dat_w[1] = bus1.dat_o;
    assign ack_w[2] = bus2.ack_o; assign err_w[2] = bus2.err_o; assign stall_w[2] = bus2.stall_o; assign dat_w[2] = bus2.dat_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Register-bank model: the outcome of one request in bus order.
    task automatic model_access(input int d, input bit w, input logic [15:0] a,
                                input logic [31:0] dt, input logic [3:0] s);
        exp_t e;
        int   idx;
        idx   = int'(a[15:2]);
        e.rd  = !w;
        e.err = 1'b0;
        e.dat = 32'd0;
        if (a[1:0] != 2'b00 || idx >= 16 || (w && idx == 0) || s == 4'd0) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int l = 0; l < 4; l++) if (s[l]) mreg[d][idx][l*8 +: 8] = dt[l*8 +: 8];
        end else begin
            e.dat = (idx == 0) ? 32'hC0DE_0002 : mreg[d][idx];
        end
        expq[d].push_back(e);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 16; r++) mreg[d][r] = 32'd0;
            expq[d].delete();
        end
    endtask

    // Present one request and hold it until the slave accepts it.
    task automatic req(input int d, input bit w, input logic [15:0] a,
                       input logic [31:0] dt, input logic [3:0] s, input bit track);
        int   n;
        logic st;
        bit   accepted;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = dt; sel[d] = s;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            st = stall_w[d];
            @(posedge clk);
            if (!st) accepted = 1'b1;
            n++;
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        if (accepted && track) model_access(d, w, a, dt, s);
        #1;
        stb[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (expq[d].size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 32'(expq[d].size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response must match the oldest tracked request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            for (int d = 0; d < 3; d++) begin
                if (stall_w[d]) stall_cnt[d]++;
                if (ack_w[d] || err_w[d]) begin
                    check("ack_err_excl", {31'd0, ack_w[d] & err_w[d]}, 32'd0);
                    n_assert++;
                    assert (expq[d].size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_resp dut=%0d: observed response expected none", d);
                    end
                    if (expq[d].size() != 0) begin
                        e = expq[d].pop_front();
                        check("resp_err", {31'd0, err_w[d]}, {31'd0, e.err});
                        check("resp_dat", dat_w[d], e.dat);
                        if (!e.err && e.rd) last_rd[d] = dat_w[d];
                    end
                    if (ack_w[d]) begin
                        ack_cnt[d]++;
                        ack_t[d].push_back(cyc_cnt);
                    end
                    if (err_w[d]) err_cnt[d]++;
                end else begin
                    check("dat_idle", dat_w[d], 32'd0);
                end
            end
        end
    end

    initial begin
        int a0, e0, s0;
        logic [15:0] a;
        for (int d = 0; d < 3; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = 0; dat[d] = 0; sel[d] = 0;
            ack_cnt[d] = 0; err_cnt[d] = 0; stall_cnt[d] = 0; last_rd[d] = 32'hFFFF_FFFF;
        end
        model_reset();

        // Reset state
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ack",   {31'd0, ack_w[d]},   32'd0);
            check("rst_err",   {31'd0, err_w[d]},   32'd0);
            check("rst_stall", {31'd0, stall_w[d]}, 32'd0);
            check("rst_dat",   dat_w[d],            32'd0);
        end
        rst_i = 1'b0;

        // ID register and a cleared register
        e0 = err_cnt[0]; a0 = ack_cnt[0];
        req(0, 0, 16'h0000, 0, 4'hF, 1);
        drain(0);
        check("id_read", last_rd[0], 32'hC0DE_0002);
        req(0, 0, 16'h0004, 0, 4'hF, 1);
        drain(0);
        check("reg1_reset", last_rd[0], 32'd0);
        check("rst_acks", 32'(ack_cnt[0] - a0), 32'd2);
        check("rst_no_err", 32'(err_cnt[0] - e0), 32'd0);

        // Byte-lane writes
        req(0, 1, 16'h0008, 32'hAABBCCDD, 4'b1111, 1);
        req(0, 1, 16'h0008, 32'h11223344, 4'b0101, 1);
        req(0, 0, 16'h0008, 0, 4'hF, 1);
        drain(0);
        check("lane_merge", last_rd[0], 32'hAA22CC44);

        // Error classes leave register 5 alone
        req(0, 1, 16'h0014, 32'h5555AAAA, 4'hF, 1);
        drain(0);
        e0 = err_cnt[0]; a0 = ack_cnt[0];
        req(0, 0, 16'h0040, 0, 4'hF, 1);
        req(0, 1, 16'h0006, 32'h12345678, 4'hF, 1);
        req(0, 1, 16'h0000, 32'h12345678, 4'hF, 1);
        req(0, 1, 16'h0014, 32'h12345678, 4'h0, 1);
        drain(0);
        check("err_count", 32'(err_cnt[0] - e0), 32'd4);
        check("err_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
        req(0, 0, 16'h0014, 0, 4'hF, 1);
        drain(0);
        check("reg5_kept", last_rd[0], 32'h5555AAAA);
        cyc[0] = 1'b0;

        // WAIT_STATES=3: stall after two accepts, acks four cycles apart in order
        for (int r = 1; r <= 4; r++) req(1, 1, 16'(4 * r), 32'h1000_0000 + 32'(r), 4'hF, 1);
        drain(1);
        ack_t[1].delete();
        req(1, 0, 16'h0004, 0, 4'hF, 1);
        req(1, 0, 16'h0008, 0, 4'hF, 1);
        check("ws3_stall_after2", {31'd0, stall_w[1]}, 32'd1);
        req(1, 0, 16'h000C, 0, 4'hF, 1);
        req(1, 0, 16'h0010, 0, 4'hF, 1);
        drain(1);
        check("ws3_last_rd", last_rd[1], 32'h1000_0004);
        check("ws3_ack_num", 32'(ack_t[1].size()), 32'd4);
        for (int i = 1; i < 4 && i < ack_t[1].size(); i++)
            check("ws3_spacing", 32'(ack_t[1][i] - ack_t[1][i-1]), 32'd4);
        cyc[1] = 1'b0;

        // WAIT_STATES=0: eight back-to-back reads, one ack per cycle, no stall
        cyc[0] = 1'b1;
        idle(1);
        ack_t[0].delete();
        s0 = stall_cnt[0];
        for (int i = 0; i < 8; i++) req(0, 0, 16'(4 * $urandom_range(0, 15)), 0, 4'hF, 1);
        drain(0);
        check("ws0_ack_num", 32'(ack_t[0].size()), 32'd8);
        for (int i = 1; i < 8 && i < ack_t[0].size(); i++)
            check("ws0_b2b", 32'(ack_t[0][i] - ack_t[0][i-1]), 32'd1);
        check("ws0_no_stall", 32'(stall_cnt[0] - s0), 32'd0);
        cyc[0] = 1'b0;

        // Abort with two writes queued on WAIT_STATES=5
        a0 = ack_cnt[2]; e0 = err_cnt[2];
        req(2, 1, 16'h0004, 32'hDEADBEEF, 4'hF, 0);
        req(2, 1, 16'h0004, 32'hCAFEF00D, 4'hF, 0);
        idle(1);
        cyc[2] = 1'b0;
        idle(12);
        check("abort_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
        check("abort_no_err", 32'(err_cnt[2] - e0), 32'd0);
        req(2, 0, 16'h0004, 0, 4'hF, 1);
        drain(2);
        check("abort_reg1", last_rd[2], 32'd0);

        // Reset with two writes queued
        req(2, 1, 16'h0008, 32'h0BADCAFE, 4'hF, 0);
        req(2, 1, 16'h000C, 32'h0BADCAFE, 4'hF, 0);
        check("pre_rst_stall", {31'd0, stall_w[2]}, 32'd1);
        rst_i = 1'b1;
        idle(1);
        check("mid_rst_ack",   {31'd0, ack_w[2]},   32'd0);
        check("mid_rst_err",   {31'd0, err_w[2]},   32'd0);
        check("mid_rst_stall", {31'd0, stall_w[2]}, 32'd0);
        check("mid_rst_dat",   dat_w[2],            32'd0);
        rst_i = 1'b0;
        model_reset();
        a0 = ack_cnt[2]; e0 = err_cnt[2];
        idle(10);
        check("mid_rst_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
        check("mid_rst_no_err", 32'(err_cnt[2] - e0), 32'd0);
        req(2, 0, 16'h0008, 0, 4'hF, 1);
        drain(2);
        check("mid_rst_reg2", last_rd[2], 32'd0);

        // Randomized traffic on every instance, then a full read-back
        for (int d = 0; d < 3; d++) begin
            cyc[d] = 1'b1;
            for (int i = 0; i < 25; i++) begin
                case ($urandom_range(0, 9))
                    0:       a = 16'h0040 + 16'(4 * $urandom_range(0, 3));
                    1:       a = 16'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                    default: a = 16'(4 * $urandom_range(0, 15));
                endcase
                req(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            for (int r = 0; r < 16; r++) req(d, 0, 16'(4 * r), 0, 4'hF, 1);
            drain(d);
            cyc[d] = 1'b0;
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
